// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the timer counter-control stage
package timer_pkg;

  localparam int DIV_MAX   = 8;
  localparam int INT_CNT_W = 8;
  localparam int DIV_VAL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/cnt_prescaler.sv
// rtl/cnt_prescaler.sv - prescaler count, limit compare, settings-change detect, div_err
//   clk, rst        : timer clock, synchronous active-high reset
//   run, freeze     : FSM qualifiers (state is RUN / state is HALT)
//   clr             : FSM is leaving RUN/HALT for IDLE on this edge
//   div_en, div_val : prescaler enable and exponent (ratio 2^div_val)
//   cnt_en          : increment strobe towards the 64-bit counter
//   div_err         : illegal prescaler setting (combinational)
//   int_cnt         : current prescaler count
module cnt_prescaler
  import timer_pkg::*;
#(
  parameter int INT_CNT_W = timer_pkg::INT_CNT_W,
  parameter int DIV_MAX   = timer_pkg::DIV_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 freeze,
  input  logic                 clr,
  input  logic                 div_en,
  input  logic [DIV_VAL_W-1:0] div_val,
  output logic                 cnt_en,
  output logic                 div_err,
  output logic [INT_CNT_W-1:0] int_cnt
);

  logic [DIV_VAL_W:0]   set_q;
  logic [INT_CNT_W-1:0] cnt_q;
  logic [INT_CNT_W-1:0] cnt_d;
  logic [INT_CNT_W-1:0] lim;
  logic [INT_CNT_W:0]   pow2;
  logic                 bypass;
  logic                 changed;

  always_comb begin
    div_err = div_en && (div_val > DIV_VAL_W'(DIV_MAX));
    bypass  = !div_en || (div_val == '0);
    // One extra bit so 2^DIV_MAX - 1 still fits after the subtract.
    pow2    = (INT_CNT_W+1)'(1) << div_val;
    lim     = INT_CNT_W'(pow2 - (INT_CNT_W+1)'(1));
    // Only a change seen while active restarts the division period.
    changed = (run || freeze) && ({div_en, div_val} != set_q);

    cnt_d = cnt_q;
    if (clr || changed || bypass || div_err) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == lim) ? '0 : cnt_q + INT_CNT_W'(1);
    end

    cnt_en = run && !div_err && (bypass || (cnt_q == lim));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      set_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      set_q <= {div_en, div_val};
    end
  end

  assign int_cnt = cnt_q;

endmodule

// File: rtl/cnt_ctrl.sv
// rtl/cnt_ctrl.sv - timer counter-control: enable/halt FSM, clear pulse, halt acknowledge
//   clk, rst        : timer clock, synchronous active-high reset
//   timer_en        : timer enable from control register
//   div_en, div_val : prescaler enable and exponent
//   dbg_mode        : debug mode active
//   halt_req        : debug halt request
//   cnt_en          : counter increment strobe
//   cnt_clr         : one-cycle counter clear after leaving RUN/HALT
//   halt_ack        : registered halt acknowledge
//   div_err         : illegal prescaler setting
//   int_cnt         : prescaler count readback
module cnt_ctrl
  import timer_pkg::*;
#(
  parameter int INT_CNT_W = timer_pkg::INT_CNT_W,
  parameter int DIV_MAX   = timer_pkg::DIV_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 timer_en,
  input  logic                 div_en,
  input  logic [DIV_VAL_W-1:0] div_val,
  input  logic                 dbg_mode,
  input  logic                 halt_req,
  output logic                 cnt_en,
  output logic                 cnt_clr,
  output logic                 halt_ack,
  output logic                 div_err,
  output logic [INT_CNT_W-1:0] int_cnt
);

  state_t state_q;
  state_t state_d;
  logic   to_idle;

  always_comb begin
    state_d = state_q;
    to_idle = (state_q != ST_IDLE) && !timer_en;
    case (state_q)
      ST_IDLE: if (timer_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!timer_en)                state_d = ST_IDLE;
        else if (dbg_mode && halt_req) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (!timer_en)                   state_d = ST_IDLE;
        else if (!halt_req || !dbg_mode) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // halt_ack is loaded from the next state so it tracks state==HALT exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_clr  <= 1'b0;
      halt_ack <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_clr  <= to_idle;
      halt_ack <= (state_d == ST_HALT);
    end
  end

  cnt_prescaler #(
    .INT_CNT_W (INT_CNT_W),
    .DIV_MAX   (DIV_MAX)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == ST_RUN),
    .freeze  (state_q == ST_HALT),
    .clr     (to_idle),
    .div_en  (div_en),
    .div_val (div_val),
    .cnt_en  (cnt_en),
    .div_err (div_err),
    .int_cnt (int_cnt)
  );

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb/tb_cnt_ctrl.sv - directed self-checking bench for cnt_ctrl
module tb_cnt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       timer_en;
  logic       div_en;
  logic [3:0] div_val;
  logic       dbg_mode;
  logic       halt_req;
  logic       cnt_en;
  logic       cnt_clr;
  logic       halt_ack;
  logic       div_err;
  logic [7:0] int_cnt;

  int tests = 0;
  int fails = 0;
  int pulses;

  always #5 clk = ~clk;

  cnt_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .div_en   (div_en),
    .div_val  (div_val),
    .dbg_mode (dbg_mode),
    .halt_req (halt_req),
    .cnt_en   (cnt_en),
    .cnt_clr  (cnt_clr),
    .halt_ack (halt_ack),
    .div_err  (div_err),
    .int_cnt  (int_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    timer_en = 1'($urandom); div_en = 1'($urandom); div_val = 4'($urandom);
    dbg_mode = 1'($urandom); halt_req = 1'($urandom);
    tick(); tick();
    chk("rst_cnt_en", cnt_en, 0);
    chk("rst_cnt_clr", cnt_clr, 0);
    chk("rst_halt_ack", halt_ack, 0);
    chk("rst_int_cnt", int_cnt, 0);
    rst = 1'b0; timer_en = 0; div_en = 0; div_val = 0; dbg_mode = 0; halt_req = 0;
    tick();

    // Bypass: 10 cycles of enable, strobe starts one cycle late
    timer_en = 1'b1;
    chk("byp_late_start", cnt_en, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("byp_cnt_en", cnt_en, 1);
      chk("byp_int_cnt", int_cnt, 0);
      chk("byp_no_clr", cnt_clr, 0);
    end
    timer_en = 1'b0;
    tick();
    chk("byp_off_cnt_en", cnt_en, 0);
    chk("byp_clr_pulse", cnt_clr, 1);
    tick();
    chk("byp_clr_end", cnt_clr, 0);

    // Divided by 4
    div_en = 1'b1; div_val = 4'd2; timer_en = 1'b1;
    tick();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      chk("div2_int_cnt", int_cnt, i % 4);
      chk("div2_cnt_en", cnt_en, (i % 4 == 3) ? 1 : 0);
      if (cnt_en) pulses++;
      tick();
    end
    chk("div2_pulses", pulses, 4);
    timer_en = 1'b0;
    tick();
    chk("div2_clr", cnt_clr, 1);
    chk("div2_cnt_cleared", int_cnt, 0);
    tick();

    // Halt at int_cnt=5 with div_val=3
    div_val = 4'd3; dbg_mode = 1'b1; timer_en = 1'b1;
    tick();
    chk("halt_entry_cnt", int_cnt, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("halt_pre_cnt", int_cnt, 5);
    halt_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("halt_ack", halt_ack, 1);
      chk("halt_cnt_en", cnt_en, 0);
      chk("halt_frozen", int_cnt, 6);
    end
    halt_req = 1'b0;
    tick();
    chk("rel_halt_ack", halt_ack, 0);
    chk("rel_cnt_held", int_cnt, 6);
    chk("rel_no_pulse", cnt_en, 0);
    tick();
    chk("rel_cnt7", int_cnt, 7);
    chk("rel_pulse", cnt_en, 1);
    tick();
    chk("rel_wrap", int_cnt, 0);
    chk("rel_pulse_end", cnt_en, 0);

    // Disable while halted
    halt_req = 1'b1;
    tick();
    chk("dh_halt_ack", halt_ack, 1);
    timer_en = 1'b0;
    tick();
    chk("dh_clr", cnt_clr, 1);
    chk("dh_halt_ack_low", halt_ack, 0);
    chk("dh_int_cnt", int_cnt, 0);
    chk("dh_cnt_en", cnt_en, 0);
    tick();
    chk("dh_clr_end", cnt_clr, 0);
    halt_req = 1'b0; dbg_mode = 1'b0;

    // Illegal setting
    div_val = 4'd9; timer_en = 1'b1;
    #1;
    chk("ill_div_err_comb", div_err, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ill_cnt_en", cnt_en, 0);
      chk("ill_int_cnt", int_cnt, 0);
      chk("ill_div_err", div_err, 1);
    end

    // Mid-run change 9 -> 4 -> 1
    div_val = 4'd4;
    tick();
    chk("chg4_cnt", int_cnt, 0);
    chk("chg4_div_err", div_err, 0);
    for (int i = 0; i < 9; i++) tick();
    chk("chg4_cnt9", int_cnt, 9);
    div_val = 4'd1;
    tick();
    chk("chg1_cleared", int_cnt, 0);
    chk("chg1_no_pulse", cnt_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("chg1_int_cnt", int_cnt, (i % 2 == 0) ? 1 : 0);
      chk("chg1_cnt_en", cnt_en, (i % 2 == 0) ? 1 : 0);
    end

    // Reset mid-run: IDLE, no clear pulse
    rst = 1'b1;
    tick();
    chk("mr_cnt_en", cnt_en, 0);
    chk("mr_int_cnt", int_cnt, 0);
    chk("mr_cnt_clr", cnt_clr, 0);
    rst = 1'b0; timer_en = 1'b0;
    tick();
    chk("mr_no_clr", cnt_clr, 0);

    // div_en=1 with div_val=0 is bypass
    div_val = 4'd0; timer_en = 1'b1;
    tick();
    chk("byp0_cnt_en", cnt_en, 1);
    tick();
    chk("byp0_cnt_en2", cnt_en, 1);
    chk("byp0_int_cnt", int_cnt, 0);
    timer_en = 1'b0;
    tick();
    chk("byp0_clr", cnt_clr, 1);
    chk("byp0_off", cnt_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cnt_ctrl.md
# cnt_ctrl

Counter-control stage of the timer IP, directly upstream of the 64-bit counter. Converts the timer enable, prescaler settings and debug-halt request into the counter's `cnt_en` increment strobe and `cnt_clr` clear pulse. Returns a halt acknowledge to the debug interface.

## Interface
Parameters:
- `INT_CNT_W`, default 8: width of the internal prescaler count; must be at least `DIV_MAX`.
- `DIV_MAX`, default 8: largest legal `div_val`.

Ports:
- `clk`  in  1  timer clock; everything is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `timer_en`  in  1  timer enable from the control register.
- `div_en`  in  1  prescaler enable.
- `div_val`  in  4  prescaler exponent; the division ratio is 2^`div_val`.
- `dbg_mode`  in  1  debug mode active.
- `halt_req`  in  1  debug halt request.
- `cnt_en`  out  1  counter increment strobe, one increment per cycle it is high.
- `cnt_clr`  out  1  counter clear pulse.
- `halt_ack`  out  1  halt acknowledge.
- `div_err`  out  1  illegal prescaler setting.
- `int_cnt`  out  `INT_CNT_W`  current prescaler count, for readback.

## Operation
- The FSM state is registered. States are IDLE, RUN and HALT.
- Transitions:
  - IDLE→RUN on an edge where `timer_en`=1.
  - RUN→HALT on an edge where `timer_en`=1, `dbg_mode`=1 and `halt_req`=1.
  - HALT→RUN on an edge where `timer_en`=1 and (`halt_req`=0 or `dbg_mode`=0).
  - RUN→IDLE and HALT→IDLE on any edge where `timer_en`=0. This has priority over every other transition.
- Prescaler bypass applies when `div_en`=0, or when `div_en`=1 and `div_val`=0. In bypass, `cnt_en` = (state==RUN) and `int_cnt` stays 0.
- Divided mode applies when `div_en`=1 and 1≤`div_val`≤`DIV_MAX`. The limit is L = 2^`div_val` − 1.
  - In RUN, `int_cnt` increments each cycle and wraps to 0 after reaching L.
  - `cnt_en` = (state==RUN) && (`int_cnt`==L), so it pulses once every 2^`div_val` cycles.
- Illegal setting: when `div_en`=1 and `div_val`>`DIV_MAX`, `div_err`=1 (combinational), `cnt_en`=0 and `int_cnt` is forced to 0.
- HALT: `cnt_en`=0 and `int_cnt` holds its value. Counting resumes from the held value on return to RUN.
- Any change of `div_en` or `div_val` while in RUN or HALT clears `int_cnt` to 0 on the next edge. A registered copy of the settings is used for change detection.
- `cnt_clr` is registered. It is high for exactly one cycle following each RUN→IDLE or HALT→IDLE transition. The same edge clears `int_cnt` to 0.
- `halt_ack` is registered and equals (state==HALT).
- `cnt_en` and `cnt_clr` are never high in the same cycle.

## Timing
- Reset: state=IDLE, `int_cnt`=0, `cnt_clr`=0, `halt_ack`=0, settings copy=0. Therefore `cnt_en`=0 and `div_err` follows its inputs.
- Reset has priority over all inputs. Asserting reset mid-run or mid-halt gives IDLE on the next edge with no `cnt_clr` pulse.
- `timer_en` rising is sampled at edge k. In bypass, `cnt_en` is high from cycle k+1, so the first counter increment happens at edge k+2.
- `timer_en` falling is sampled at edge k. `cnt_en` goes low and `cnt_clr` goes high in cycle k+1; `cnt_clr` is low again from edge k+2.
- `halt_req` is sampled at edge k. `halt_ack`=1 and `cnt_en`=0 from cycle k+1. After release, `halt_ack` drops one cycle after `halt_req` is sampled low.
- Divided mode: the first `cnt_en` pulse after entering RUN comes 2^`div_val` cycles after the RUN entry edge.

## Structure
- Shared package `timer_pkg` holds:
  - the state enum (IDLE/RUN/HALT);
  - the constants `DIV_MAX`=8 and `INT_CNT_W`=8;
  - the `div_val` width constant.
- Sub-module `cnt_prescaler` contains `int_cnt`, the limit compare, the settings-change detect and `div_err`. It takes a `run` and a `freeze` qualifier from the FSM. The FSM, `cnt_clr` and `halt_ack` stay in `cnt_ctrl`.

## Test plan
- Reset check: drive `rst`=1 for 2 cycles with random inputs → `cnt_en`=0, `cnt_clr`=0, `halt_ack`=0, `int_cnt`=0.
- Bypass mode: `div_en`=0, `timer_en`=1 for 10 cycles then 0 → `cnt_en` high for 10 cycles starting one cycle late, then a single `cnt_clr` pulse.
- Divided mode: `div_en`=1, `div_val`=2, RUN for 16 cycles → `int_cnt` runs 0,1,2,3,0…; `cnt_en` gives 4 pulses, each when `int_cnt`=3.
- Halt: `div_val`=3, `dbg_mode`=1, `halt_req` asserted at `int_cnt`=5 for 6 cycles → `halt_ack`=1, `cnt_en`=0, `int_cnt` frozen at 5 or 6. After release the count resumes and the next `cnt_en` pulse occurs at `int_cnt`=7.
- Illegal setting and mid-run change: `div_val`=9 → `div_err`=1 and no `cnt_en`. Switching `div_val` from 4 to 1 at `int_cnt`=9 → `int_cnt` becomes 0 and pulses every 2 cycles.
- Disable during halt: `timer_en` dropped while in HALT → IDLE, one `cnt_clr` pulse, `halt_ack`=0.
